// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow signal in clock_in cycles, with loss-of-signal timeout
//   clock_in   system clock, all logic on its rising edge
//   reset      synchronous active-high reset
//   sig_in     measured signal, asynchronous to clock_in
//   period     last measured period (clock_in cycles)
//   high_time  last measured high time (clock_in cycles)
//   meas_valid one-cycle pulse when period/high_time update
//   locked     a measurement has completed since reset or the last timeout
//   timeout    no rising edge seen for TIMEOUT cycles
module clk_period_meter #(
  parameter int CNT_W = 28,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd100000000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);
  typedef enum logic {WAIT_FIRST, MEASURE} state_t;
  state_t state, state_next;
  logic s1, s2, s3;
  logic rise, expire;
  logic [CNT_W-1:0] cnt, hcnt;
  assign rise = s2 & ~s3;
  // a rise in the same cycle the count hits TIMEOUT takes priority over expiry
  assign expire = (cnt == TIMEOUT) & ~rise;
  always_comb begin
    state_next = state;
    state_next = rise ? MEASURE : expire ? WAIT_FIRST : state;
  end
  // counters restart at 1 on a rise because the edge cycle itself belongs to the new window
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= WAIT_FIRST;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= rise && state == MEASURE;
      cnt        <= rise ? CNT_W'(1) : (cnt == TIMEOUT) ? cnt : cnt + 1'b1;
      hcnt       <= rise ? CNT_W'(1) : (hcnt == TIMEOUT || !s2) ? hcnt : hcnt + 1'b1;
      if (rise) begin
        timeout <= 1'b0;
        if (state == MEASURE) begin
          period    <= cnt;
          high_time <= hcnt;
          locked    <= 1'b1;
        end
      end else if (expire) begin
        timeout   <= 1'b1;
        locked    <= 1'b0;
        period    <= '0;
        high_time <= '0;
      end
    end
  end
endmodule
